p4_mem_stage: RTL and testbench

P4 memory-access stage datapath and control. It takes the instruction held in P4, issues data-memory load/store requests over a valid/ready request channel with a separate response channel, and aligns and sign-extends load data. It then drives the p4p5_t bundle into the P4/P5 pipeline register. It stalls the upstream pipeline while a memory transaction is outstanding, and presents a NOP bubble downstream while stalled.

---
 rtl/p4_mem_stage.sv | 181 ++++++++++++++++++
 tb/tb_p4_mem_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p4_mem_stage.sv
// P4 memory-access stage: issues data-memory requests, formats load data, drives the P4/P5 bundle.
// Optional MISALIGN_TRAP_EN: flag misaligned half/word accesses instead of issuing them.
package p4_mem_stage_pkg;
    localparam int unsigned P4P5_CTRL_W = 8;

    typedef struct packed {
        logic [31:0]            alu_out;
        logic [31:0]            mem_rdata;
        logic [4:0]             reg_wr_port;
        logic [P4P5_CTRL_W-1:0] ctrl;
        logic [31:0]            insn;
    } p4p5_t;
endpackage

module p4_mem_stage
    import p4_mem_stage_pkg::*;
#(
    // Must match P4P5_CTRL_W, which sizes the ctrl field of p4p5_t
    parameter int unsigned CTRL_W = P4P5_CTRL_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [31:0]       i_alu_out,
    input  logic [31:0]       i_store_data,
    input  logic              i_mem_rd,
    input  logic              i_mem_wr,
    input  logic [2:0]        i_funct3,
    input  logic [4:0]        i_reg_wr_port,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [31:0]       i_insn,
    output p4p5_t             o_p4p5,
    output logic              o_stall,
    output logic              o_dmem_req_valid,
    input  logic              i_dmem_req_ready,
    output logic [31:0]       o_dmem_addr,
    output logic              o_dmem_we,
    output logic [3:0]        o_dmem_wstrb,
    output logic [31:0]       o_dmem_wdata,
    input  logic              i_dmem_rsp_valid,
    input  logic [31:0]       i_dmem_rdata,
    input  logic              i_dmem_err,
    output logic              o_bus_err,
    output logic              o_misalign
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e      r_state, nxt_state;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        mem_op, is_load, trap, bubble;
    logic [1:0]  lane;
    logic [3:0]  wstrb;
    logic [31:0] wdata, load_fmt;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign lane    = i_alu_out[1:0];
    assign mem_op  = i_valid & (i_mem_rd | i_mem_wr);
    assign is_load = i_mem_rd;

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((i_funct3[1:0] == 2'b01) & lane[0]) |
                        ((i_funct3[1:0] == 2'b10) & (lane != 2'b00));
    assign trap = mem_op & misaligned & (r_state == StIdle);
`else
    assign trap = 1'b0;
`endif
    assign o_misalign = trap;

    // Store lane steering; half/word ignore the low address bits they cannot use
    always_comb begin
        wstrb = 4'b1111;
        wdata = i_store_data;
        case (i_funct3[1:0])
            2'b00: begin
                wstrb = 4'b0001 << lane;
                wdata = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                wstrb = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{i_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    assign o_dmem_addr  = {i_alu_out[31:2], 2'b00};
    assign o_dmem_we    = ~is_load;
    assign o_dmem_wstrb = is_load ? 4'b0000 : wstrb;
    assign o_dmem_wdata = wdata;

    always_comb begin
        ld_byte = i_dmem_rdata[7:0];
        case (lane)
            2'd1:    ld_byte = i_dmem_rdata[15:8];
            2'd2:    ld_byte = i_dmem_rdata[23:16];
            2'd3:    ld_byte = i_dmem_rdata[31:24];
            default: ;
        endcase
        ld_half  = lane[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        load_fmt = i_dmem_rdata;
        case (i_funct3[1:0])
            2'b00:   load_fmt = {{24{~i_funct3[2] & ld_byte[7]}}, ld_byte};
            2'b01:   load_fmt = {{16{~i_funct3[2] & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

    always_comb begin
        nxt_state        = r_state;
        o_dmem_req_valid = 1'b0;
        o_stall          = 1'b0;
        case (r_state)
            StIdle: begin
                if (mem_op && !trap) begin
                    o_dmem_req_valid = 1'b1;
                    if (is_load) begin
                        o_stall   = 1'b1;
                        nxt_state = i_dmem_req_ready ? StWait : StReq;
                    end else if (!i_dmem_req_ready) begin
                        o_stall   = 1'b1;
                        nxt_state = StReq;
                    end
                end
            end
            StReq: begin
                o_dmem_req_valid = 1'b1;
                o_stall          = 1'b1;
                if (i_dmem_req_ready) begin
                    // Posted store releases the pipeline on the accept cycle
                    if (is_load) begin
                        nxt_state = StWait;
                    end else begin
                        o_stall   = 1'b0;
                        nxt_state = StIdle;
                    end
                end
            end
            StWait: begin
                o_stall = 1'b1;
                if (i_dmem_rsp_valid) nxt_state = StDone;
            end
            StDone:  nxt_state = StIdle;
            default: nxt_state = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= nxt_state;
            if (r_state == StWait && i_dmem_rsp_valid) begin
                r_rdata <= i_dmem_err ? '0 : load_fmt;
                r_err   <= i_dmem_err;
            end
        end
    end

    assign o_bus_err = (r_state == StDone) & r_err;
    assign bubble    = o_stall | ~i_valid | trap;

    always_comb begin
        o_p4p5      = '0;
        o_p4p5.insn = NOP;
        if (!bubble) begin
            o_p4p5.alu_out     = i_alu_out;
            o_p4p5.mem_rdata   = (r_state == StDone) ? r_rdata : '0;
            o_p4p5.reg_wr_port = i_reg_wr_port;
            o_p4p5.ctrl        = i_ctrl;
            o_p4p5.insn        = i_insn;
        end
    end
endmodule

// File: tb/tb_p4_mem_stage.sv
// Randomized self-checking bench for p4_mem_stage: a per-instruction timeline model sets the
// expected outputs for every cycle and one compare process checks them on the falling edge.
module tb_p4_mem_stage;
    import p4_mem_stage_pkg::*;

    localparam int unsigned CTRL_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_valid, i_mem_rd, i_mem_wr;
    logic [31:0]       i_alu_out, i_store_data, i_insn;
    logic [2:0]        i_funct3;
    logic [4:0]        i_reg_wr_port;
    logic [CTRL_W-1:0] i_ctrl;
    p4p5_t             p4p5;
    logic              o_stall, o_dmem_req_valid, o_dmem_we, o_bus_err, o_misalign;
    logic              i_dmem_req_ready, i_dmem_rsp_valid, i_dmem_err;
    logic [31:0]       o_dmem_addr, o_dmem_wdata, i_dmem_rdata;
    logic [3:0]        o_dmem_wstrb;

    always #5 clk = ~clk;

    p4_mem_stage #(.CTRL_W(CTRL_W)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_valid          (i_valid),
        .i_alu_out        (i_alu_out),
        .i_store_data     (i_store_data),
        .i_mem_rd         (i_mem_rd),
        .i_mem_wr         (i_mem_wr),
        .i_funct3         (i_funct3),
        .i_reg_wr_port    (i_reg_wr_port),
        .i_ctrl           (i_ctrl),
        .i_insn           (i_insn),
        .o_p4p5           (p4p5),
        .o_stall          (o_stall),
        .o_dmem_req_valid (o_dmem_req_valid),
        .i_dmem_req_ready (i_dmem_req_ready),
        .o_dmem_addr      (o_dmem_addr),
        .o_dmem_we        (o_dmem_we),
        .o_dmem_wstrb     (o_dmem_wstrb),
        .o_dmem_wdata     (o_dmem_wdata),
        .i_dmem_rsp_valid (i_dmem_rsp_valid),
        .i_dmem_rdata     (i_dmem_rdata),
        .i_dmem_err       (i_dmem_err),
        .o_bus_err        (o_bus_err),
        .o_misalign       (o_misalign)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected outputs for the current cycle, written by the driver
    logic        e_chk = 1'b0;
    logic        e_stall, e_req, e_bubble, e_bus_err, e_misalign, e_we;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata, e_mem_rdata;

    // Observations used by the literal checks of directed cases
    int          n_stall, n_req, n_buserr, n_misal;
    p4p5_t       last_out;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_wstrb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                           input logic [2:0] f3);
        logic [31:0] v;
        if (f3[1:0] == 2'b00) begin
            v = (w >> (8 * a[1:0])) & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v - 32'h100;
        end else if (f3[1:0] == 2'b01) begin
            v = (w >> (16 * a[1])) & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [31:0] a, input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 4'(1 << a[1:0]);
        if (f3[1:0] == 2'b01) return 4'(3 << (2 * a[1]));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic m_misal(input logic [31:0] a, input logic [2:0] f3);
        return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
    endfunction

    always @(negedge clk) begin
        if (e_chk) begin
            chk("stall", 32'(o_stall), 32'(e_stall));
            chk("req_valid", 32'(o_dmem_req_valid), 32'(e_req));
            chk("misalign", 32'(o_misalign), 32'(e_misalign));
            chk("bus_err", 32'(o_bus_err), 32'(e_bus_err));
            if (e_req) begin
                chk("addr", o_dmem_addr, {i_alu_out[31:2], 2'b00});
                chk("we", 32'(o_dmem_we), 32'(e_we));
                chk("wstrb", 32'(o_dmem_wstrb), 32'(e_wstrb));
                if (e_we) chk("wdata", o_dmem_wdata, e_wdata);
            end
            if (e_bubble) begin
                chk("bubble_insn", p4p5.insn, 32'h0000_0013);
                chk("bubble_alu", p4p5.alu_out, 32'h0);
                chk("bubble_rdata", p4p5.mem_rdata, 32'h0);
                chk("bubble_rd_ctrl", {p4p5.reg_wr_port, p4p5.ctrl}, 32'h0);
            end else begin
                chk("alu_out", p4p5.alu_out, i_alu_out);
                chk("insn", p4p5.insn, i_insn);
                chk("rd_ctrl", {p4p5.reg_wr_port, p4p5.ctrl}, {i_reg_wr_port, i_ctrl});
                chk("mem_rdata", p4p5.mem_rdata, e_mem_rdata);
                last_out = p4p5;
            end
        end
        if (o_stall) n_stall++;
        if (o_bus_err) n_buserr++;
        if (o_misalign) n_misal++;
        if (o_dmem_req_valid) begin
            n_req++;
            last_addr  = o_dmem_addr;
            last_wstrb = o_dmem_wstrb;
            last_wdata = o_dmem_wdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        n_stall  = 0;
        n_req    = 0;
        n_buserr = 0;
        n_misal  = 0;
        last_out = '0;
    endtask

    // Drives one instruction through its whole timeline: r cycles of ready low, then accept,
    // then (loads) a response lat cycles after accept, then the completion cycle.
    task automatic run_insn(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd, input int r,
                            input int lat, input logic [31:0] rw, input logic err);
        logic is_mem, trap;
        i_valid          = v;
        i_mem_rd         = rd;
        i_mem_wr         = wr;
        i_funct3         = f3;
        i_alu_out        = a;
        i_store_data     = sd;
        i_insn           = $urandom;
        i_ctrl           = CTRL_W'($urandom);
        i_reg_wr_port    = 5'($urandom);
        i_dmem_rsp_valid = 1'b0;
        i_dmem_err       = 1'b0;
        i_dmem_rdata     = $urandom;
        is_mem           = v && (rd || wr);
        trap             = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = is_mem && m_misal(a, f3);
`endif
        e_we        = !rd;
        e_wstrb     = rd ? 4'h0 : m_wstrb(a, f3);
        e_wdata     = m_wdata(sd, f3);
        e_misalign  = trap;
        e_bus_err   = 1'b0;
        e_mem_rdata = '0;
        e_chk       = 1'b1;
        if (!is_mem || trap) begin
            i_dmem_req_ready = 1'($urandom);
            e_req    = 1'b0;
            e_stall  = 1'b0;
            e_bubble = !v || trap;
            step();
        end else begin
            for (int c = 0; c <= r; c++) begin
                i_dmem_req_ready = (c == r);
                e_req    = 1'b1;
                e_stall  = rd || (c < r);
                e_bubble = e_stall;
                step();
            end
            e_misalign = 1'b0;
            if (rd) begin
                e_req    = 1'b0;
                e_stall  = 1'b1;
                e_bubble = 1'b1;
                for (int k = 1; k <= lat; k++) begin
                    i_dmem_req_ready = 1'($urandom);
                    i_dmem_rsp_valid = (k == lat);
                    i_dmem_rdata     = (k == lat) ? rw : $urandom;
                    i_dmem_err       = (k == lat) ? err : 1'($urandom);
                    step();
                end
                i_dmem_rsp_valid = 1'b0;
                i_dmem_err       = 1'b0;
                i_dmem_rdata     = $urandom;
                e_stall     = 1'b0;
                e_bubble    = 1'b0;
                e_bus_err   = err;
                e_mem_rdata = err ? 32'h0 : m_load(rw, a, f3);
                step();
            end
        end
        e_chk = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic       rd, wr;
        logic [2:0] f3;
        rst_n = 1'b0;
        {i_valid, i_mem_rd, i_mem_wr, i_funct3} = '0;
        {i_alu_out, i_store_data, i_insn, i_reg_wr_port, i_ctrl} = '0;
        {i_dmem_req_ready, i_dmem_rsp_valid, i_dmem_err, i_dmem_rdata} = '0;
        clear_obs();

        @(negedge clk);
        chk("rst_stall", 32'(o_stall), 32'h0);
        chk("rst_req", 32'(o_dmem_req_valid), 32'h0);
        chk("rst_bus_err", 32'(o_bus_err), 32'h0);
        chk("rst_insn", p4p5.insn, 32'h0000_0013);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        clear_obs();
        run_insn(1, 0, 0, 3'b000, 32'h0000_1234, 32'h0, 0, 1, 32'h0, 0);
        chk("alu_pass_value", last_out.alu_out, 32'h0000_1234);
        chk("alu_no_req", 32'(n_req), 32'h0);

        clear_obs();
        run_insn(1, 0, 1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 1, 32'h0, 0);
        chk("sb_wstrb", 32'(last_wstrb), 32'h8);
        chk("sb_wdata", last_wdata, 32'hABAB_ABAB);
        chk("sb_addr", last_addr, 32'h0000_1000);
        chk("sb_no_stall", 32'(n_stall), 32'h0);

        clear_obs();
        run_insn(1, 1, 0, 3'b000, 32'h0000_2001, 32'h0, 2, 3, 32'h0000_8000, 0);
        chk("lb_stall_cycles", 32'(n_stall), 32'd6);
        chk("lb_rdata", last_out.mem_rdata, 32'hFFFF_FF80);

        clear_obs();
        run_insn(1, 1, 0, 3'b101, 32'h0000_2002, 32'h0, 0, 1, 32'hBEEF_0000, 0);
        chk("lhu_rdata", last_out.mem_rdata, 32'h0000_BEEF);

        clear_obs();
        run_insn(1, 1, 0, 3'b010, 32'h0000_2004, 32'h0, 1, 2, 32'h1234_5678, 1);
        chk("err_pulse_count", 32'(n_buserr), 32'h1);
        chk("err_rdata", last_out.mem_rdata, 32'h0);

        clear_obs();
        run_insn(1, 1, 0, 3'b010, 32'h0000_3002, 32'h0, 0, 1, 32'hCAFE_F00D, 0);
`ifdef MISALIGN_TRAP_EN
        chk("lw_mis_flag", 32'(n_misal), 32'h1);
        chk("lw_mis_no_req", 32'(n_req), 32'h0);
`else
        chk("lw_mis_addr", last_addr, 32'h0000_3000);
        chk("lw_mis_rdata", last_out.mem_rdata, 32'hCAFE_F00D);
`endif

        // Reset while a load is waiting for its response
        i_valid          = 1'b1;
        i_mem_rd         = 1'b1;
        i_mem_wr         = 1'b0;
        i_funct3         = 3'b010;
        i_alu_out        = 32'h0000_4000;
        i_dmem_req_ready = 1'b1;
        step();
        i_dmem_req_ready = 1'b0;
        #2;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(o_stall), 32'h0);
        chk("rst_mid_req", 32'(o_dmem_req_valid), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        for (int n = 0; n < 400; n++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            f3 = (wr && !rd) ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            run_insn(($urandom_range(0, 7) != 0), rd, wr, f3, $urandom, $urandom,
                     $urandom_range(0, 3), $urandom_range(1, 4), $urandom,
                     ($urandom_range(0, 5) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
